decoder_seq: RTL and testbench

DECODER_SEQ -- requirements
Module: decoder_seq

---
 rtl/decoder_seq.sv | 142 ++++++++++++++
 tb/tb_decoder_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
// Binary-to-word decoder with one-hot, thermometer and multi-beat scan modes.
// Latency: one cycle from accept to out_valid; scan emits target+1 beats.
// Backpressure: out_ready low freezes the held beat; in_ready follows out_ready in HOLD, low in SCAN.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  request handshake; binary/mode sampled on accept
//   binary [N-1:0]      index to decode
//   mode [1:0]          00 one-hot, 01 thermometer, 10 scan, 11 illegal
//   out_valid, out_ready  output beat handshake
//   one_hot [2**N-1:0]  decoded word, zero whenever out_valid is low
//   busy                high while a scan sequence is running
//   err                 sticky flag, set by an illegal-mode request
module decoder_seq #(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        binary,
    input  logic [1:0]          mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [(1<<N)-1:0]   one_hot,
    output logic                busy,
    output logic                err
);

    localparam int W = 1 << N;

    localparam logic [1:0] MODE_ONEHOT  = 2'b00;
    localparam logic [1:0] MODE_THERM   = 2'b01;
    localparam logic [1:0] MODE_SCAN    = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        SCAN = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   oh_q, oh_d;
    logic [N-1:0]   idx_q, idx_d;
    logic [N-1:0]   target_q, target_d;
    logic [N-1:0]   idx_inc;
    logic           err_q, err_d;
    // Low through reset and for the first edge after it, so in_ready only
    // rises once the block has seen a clock out of reset.
    logic           ready_q;
    logic           accept;
    logic           take;

    assign out_valid = (state_q != IDLE);
    assign take      = out_valid & out_ready;
    assign idx_inc   = idx_q + 1'b1;
    assign busy      = (state_q == SCAN);
    assign err       = err_q;
    // The register is already cleared on entry to IDLE; the gate makes the
    // zero-when-invalid property hold structurally.
    assign one_hot   = out_valid ? oh_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            oh_q     <= '0;
            idx_q    <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            oh_q     <= oh_d;
            idx_q    <= idx_d;
            target_q <= target_d;
            err_q    <= err_d;
            ready_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        oh_d     = oh_q;
        idx_d    = idx_q;
        target_d = target_q;
        err_d    = err_q;
        in_ready = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE:    in_ready = ready_q;
            HOLD:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase

        accept = in_valid & in_ready;

        // An accept in HOLD always coincides with the held beat being taken,
        // so loading the new request here gives back-to-back beats.
        if (accept) begin
            case (mode)
                MODE_ONEHOT: begin
                    oh_d         = '0;
                    oh_d[binary] = 1'b1;
                    state_d      = HOLD;
                end
                MODE_THERM: begin
                    for (int i = 0; i < W; i++) begin
                        oh_d[i] = (i <= int'(binary));
                    end
                    state_d = HOLD;
                end
                MODE_SCAN: begin
                    target_d = binary;
                    idx_d    = '0;
                    oh_d     = {{(W-1){1'b0}}, 1'b1};
                    state_d  = SCAN;
                end
                MODE_ILLEGAL: begin
                    oh_d    = '0;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end
                default: begin
                    oh_d    = '0;
                    state_d = HOLD;
                end
            endcase
        end else if (take) begin
            if ((state_q == SCAN) && (idx_q != target_q)) begin
                idx_d          = idx_inc;
                oh_d           = '0;
                oh_d[idx_inc]  = 1'b1;
            end else begin
                state_d = IDLE;
                oh_d    = '0;
            end
        end
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: directed scenarios plus randomized traffic.
// Reference is a queue of pending output beats built per accepted request.
// Output readiness is driven randomly to exercise stalls and back-to-back loads.
module tb_decoder_seq;

    localparam int N = 4;
    localparam int W = 1 << N;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   binary;
    logic [1:0]     mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   one_hot;
    logic           busy;
    logic           err;

    decoder_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .binary    (binary),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .one_hot   (one_hot),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] beat;
        bit          scan;
    } ent_t;

    ent_t           q[$];
    logic [W-1:0]   taken[$];
    bit             err_m;
    bit             rdy_m;
    int             n_checks;
    int             n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, compare outputs with the beat queue,
    // then advance the queue by what the handshakes should have done.
    task automatic step(input bit rst, input bit iv, input int b, input int m, input bit ordy);
        logic [63:0] exp_oh;
        bit          exp_rdy;
        bit          acc;
        bit          tk;
        @(negedge clk);
        rst_n     = rst;
        in_valid  = iv;
        binary    = b[N-1:0];
        mode      = m[1:0];
        out_ready = ordy;
        if (!rst) begin
            q.delete();
            err_m = 1'b0;
            rdy_m = 1'b0;
        end
        #1;
        exp_rdy = rdy_m && ((q.size() == 0) || (!q[0].scan && ordy));
        exp_oh  = (q.size() != 0) ? q[0].beat : 64'd0;
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        check("one_hot",   64'(one_hot),   exp_oh);
        check("busy",      64'(busy),      64'((q.size() != 0) && q[0].scan));
        check("err",       64'(err),       64'(err_m));
        check("in_ready",  64'(in_ready),  64'(exp_rdy));
        if (out_valid && out_ready) taken.push_back(one_hot);
        acc = iv && exp_rdy;
        tk  = (q.size() != 0) && ordy;
        if (tk) void'(q.pop_front());
        if (acc) begin
            case (m)
                0: q.push_back('{beat: 64'd1 << b, scan: 1'b0});
                1: q.push_back('{beat: (64'd2 << b) - 64'd1, scan: 1'b0});
                2: for (int k = 0; k <= b; k++) q.push_back('{beat: 64'd1 << k, scan: 1'b1});
                default: q.push_back('{beat: 64'd0, scan: 1'b0});
            endcase
        end
        @(posedge clk);
        if (acc && (m == 3)) err_m = 1'b1;
        rdy_m = rst;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        err_m     = 1'b0;
        rdy_m     = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        binary    = '0;
        mode      = 2'b00;
        out_ready = 1'b0;

        // Reset state, then the first cycle out of reset with in_ready still low.
        step(1'b0, 1'b1, 3, 0, 1'b1);
        step(1'b0, 1'b1, 3, 0, 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        drain();

        // One-hot decode of 9.
        step(1'b1, 1'b1, 9, 0, 1'b1);
        check("oh9_valid", 64'(out_valid), 64'd1);
        check("oh9_word",  64'(one_hot),   64'h0200);
        check("oh9_ready", 64'(in_ready),  64'd1);
        drain();

        // Thermometer 3 then 15 back-to-back.
        step(1'b1, 1'b1, 3, 1, 1'b1);
        check("therm3", 64'(one_hot), 64'h000F);
        step(1'b1, 1'b1, 15, 1, 1'b1);
        check("therm15", 64'(one_hot), 64'hFFFF);
        drain();

        // Scan to 3 with a stall on the second beat; in_valid held high throughout.
        taken.delete();
        step(1'b1, 1'b1, 3, 2, 1'b1);
        check("scan_busy", 64'(busy), 64'd1);
        step(1'b1, 1'b1, 0, 0, 1'b1);
        step(1'b1, 1'b1, 0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b1);
        step(1'b1, 1'b1, 0, 0, 1'b1);
        step(1'b1, 1'b1, 0, 0, 1'b1);
        check("scan_done_busy", 64'(busy), 64'd0);
        check("scan_count", 64'(taken.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < taken.size()) check("scan_beat", 64'(taken[k]), 64'd1 << k);
        end
        step(1'b1, 1'b0, 0, 0, 1'b0);
        drain();

        // Stall a single one-hot beat for four cycles, then release.
        taken.delete();
        step(1'b1, 1'b1, 5, 0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 7, 0, 1'b0);
        check("stall_word",  64'(one_hot),  64'h0020);
        check("stall_ready", 64'(in_ready), 64'd0);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        check("stall_release", 64'(out_valid), 64'd0);
        check("stall_count", 64'(taken.size()), 64'd1);
        drain();

        // Illegal mode: zero beat, sticky err.
        step(1'b1, 1'b1, 7, 3, 1'b1);
        check("ill_valid", 64'(out_valid), 64'd1);
        check("ill_word",  64'(one_hot),   64'd0);
        check("ill_err",   64'(err),       64'd1);
        step(1'b1, 1'b1, 2, 0, 1'b1);
        check("ill_err_sticky", 64'(err), 64'd1);
        drain();

        // Scan to 15 aborted by reset after the third beat.
        step(1'b1, 1'b1, 15, 2, 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        check("rst_word",  64'(one_hot), 64'd0);
        check("rst_busy",  64'(busy),    64'd0);
        check("rst_err",   64'(err),     64'd0);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        step(1'b1, 1'b1, 0, 0, 1'b1);
        check("post_rst_word", 64'(one_hot), 64'h0001);
        drain();

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            bit iv;
            bit ordy;
            int m;
            int b;
            r    = ($urandom_range(0, 299) != 0);
            iv   = ($urandom_range(0, 9) < 6);
            ordy = ($urandom_range(0, 9) < 7);
            m    = ($urandom_range(0, 39) == 0) ? 3 : int'($urandom_range(0, 2));
            b    = int'($urandom_range(0, W - 1));
            step(r, iv, b, m, ordy);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
